signal_param_meter: RTL and testbench
=====================================

Name: signal_param_meter

Overview:
Measurement front end that produces the parameter bus consumed by the auto-test/threshold logic: freq, amplitude, duty and a param_valid strobe. Operates on a digitized ADC stream over a fixed gate window. Uses an adaptive-midpoint hysteresis comparator, peak tracking and a sequential divider for duty. Publishes one parameter set per window.

Parameters:
GATE_CYCLES, 100000000, gate window length in clk cycles (1 s at 100 MHz, so freq reads in Hz)
ADC_W, 12, ADC sample width, unsigned
HYST, 16, comparator hysteresis in LSB, applied on each side of the midpoint
DEFAULT_MID, 2048, comparator midpoint after reset and for the first window

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
meas_enable  in  1  run continuous measurement windows
adc_data  in  ADC_W  sample, unsigned
adc_valid  in  1  sample qualifier
freq  out  16  rising crossings per window, saturating at 65535
amplitude  out  16  peak-to-peak (max-min), zero-extended
duty  out  16  high fraction, 0-1000 = 0-100.0%
param_valid  out  1  one-cycle strobe; freq/amplitude/duty are new and stable
busy  out  1  state != IDLE

Behaviour:
- Reset: freq/amplitude/duty = 0, param_valid = 0, busy = 0, state IDLE, mid = DEFAULT_MID, comparator output = 0.
- States: IDLE, MEASURE, DIVIDE, UPDATE.
- IDLE: meas_enable=1 causes MEASURE on the next cycle. Entry into MEASURE clears gate_cnt, edge_cnt, high_cnt, total_cnt. It also sets win_max=0 and win_min=all ones.
- MEASURE, every cycle: gate_cnt++.
- MEASURE, on adc_valid:
  - total_cnt++; update win_max/win_min.
  - Comparator: if cmp=0 and data >= mid+HYST, then cmp=1 and edge_cnt++ (saturating). If cmp=1 and data <= mid-HYST, then cmp=0.
  - Thresholds clamp to [0, 2^ADC_W-1].
  - high_cnt++ when the post-update cmp=1.
- MEASURE exit: at gate_cnt == GATE_CYCLES-1, go to DIVIDE. The sample on that last cycle is included.
- meas_enable=0 during MEASURE: go to IDLE next cycle. No param_valid; outputs keep their previous values; comparator state is kept.
- DIVIDE: restoring divider computes duty = floor(high_cnt*1000 / total_cnt).
  - 40-bit numerator, 1 quotient bit per cycle, fixed 40 cycles.
  - If total_cnt == 0, duty = 0 and the same 40-cycle latency is kept.
  - meas_enable is ignored here.
- UPDATE: one cycle.
  - Register freq = edge_cnt.
  - Register amplitude = win_max-win_min, or 0 if total_cnt == 0.
  - Register duty.
  - param_valid = 1 in the following cycle only.
  - mid <= (win_max+win_min)>>1 if total_cnt > 0, otherwise unchanged.
  - Next state: MEASURE if meas_enable, else IDLE.
- Timing: with t0 = first MEASURE cycle, param_valid is high at t0+GATE_CYCLES+41. Back-to-back window period is GATE_CYCLES+41 cycles. Samples arriving in DIVIDE/UPDATE are dropped.
- Outputs change only together with param_valid.
- Counter widths: gate/total/high 32 bits; edge 16 bits, saturating.

Optional Feature:
AMP_AVG_EN:
- Defined: amplitude = (pp_current + pp_previous)>>1, using a 17-bit sum. pp_previous is reset to 0, so the first window reports half of its peak-to-peak. pp_previous is updated every UPDATE.
- Undefined: amplitude = pp_current.

Test Plan:
1. GATE_CYCLES=1000, adc_valid=1, square wave 3000 for 25 cycles / 1000 for 75 cycles, starting high -> param_valid at t0+1041: freq=10, amplitude=2000, duty=250. Next window uses mid=2000 and gives the same result; the next param_valid comes 1041 cycles later.
2. Constant 2048 -> freq=0, amplitude=0, duty=0. mid stays 2048.
3. Samples alternating 2050/2040 with mid=2048, HYST=16 -> freq=0, duty=0, amplitude=10.
4. adc_valid held 0 for the whole window -> param_valid still pulses with freq=0, amplitude=0, duty=0. mid unchanged.
5. meas_enable dropped at MEASURE cycle 500 -> no param_valid, busy=0 two cycles later, outputs hold the prior values. Re-enable -> a full new window starts with cleared counters.
6. AMP_AVG_EN defined: window 1 peak-to-peak 2000, window 2 peak-to-peak 1000 -> amplitude 1000 then 1500.

Source files
------------

// File: rtl/signal_param_meter.sv
// Windowed signal measurement: frequency, peak-to-peak amplitude and duty cycle.
// Optional macro AMP_AVG_EN averages amplitude over the current and previous window.
module signal_param_meter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int ADC_W       = 12,
    parameter int HYST        = 16,
    parameter int DEFAULT_MID = 2048
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             meas_enable,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    output logic [15:0]      freq,
    output logic [15:0]      amplitude,
    output logic [15:0]      duty,
    output logic             param_valid,
    output logic             busy
);

    localparam logic [ADC_W-1:0] ADC_MAX   = '1;
    localparam logic [ADC_W:0]   HYST_X    = (ADC_W+1)'(HYST);
    localparam logic [ADC_W-1:0] HYST_L    = ADC_W'(HYST);
    localparam logic [31:0]      GATE_LAST = 32'(GATE_CYCLES - 1);
    localparam logic [5:0]       DIV_LAST  = 6'd39;

    typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE, UPDATE} state_t;

    state_t state, state_nxt;

    logic [31:0]      gate_cnt, total_cnt, high_cnt;
    logic [31:0]      total_nxt, high_nxt;
    logic [15:0]      edge_cnt, edge_nxt;
    logic [ADC_W-1:0] win_max, win_min, mid;
    logic [ADC_W-1:0] hi_th, lo_th, pp_diff;
    logic [ADC_W:0]   hi_sum;
    logic             cmp, cmp_nxt;
    logic             sample_take, start_window;

    logic [5:0]  div_cnt;
    logic [39:0] div_num;
    logic [31:0] div_rem, div_den;
    logic [15:0] div_quo;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [15:0] pp_cur, amp_nxt;

`ifdef AMP_AVG_EN
    logic [15:0] pp_prev;
`endif

    // Hysteresis thresholds around the adaptive midpoint, clamped to the ADC range.
    assign hi_sum = {1'b0, mid} + HYST_X;
    assign hi_th  = (hi_sum > {1'b0, ADC_MAX}) ? ADC_MAX : hi_sum[ADC_W-1:0];
    assign lo_th  = ({1'b0, mid} < HYST_X) ? '0 : (mid - HYST_L);

    assign sample_take  = (state == MEASURE) && adc_valid;
    assign start_window = (state_nxt == MEASURE) && (state != MEASURE);
    assign busy         = (state != IDLE);

    always_comb begin
        cmp_nxt   = cmp;
        edge_nxt  = edge_cnt;
        total_nxt = total_cnt;
        high_nxt  = high_cnt;
        if (sample_take) begin
            total_nxt = total_cnt + 32'd1;
            if (!cmp && (adc_data >= hi_th)) begin
                cmp_nxt = 1'b1;
                if (edge_cnt != 16'hffff) edge_nxt = edge_cnt + 16'd1;
            end else if (cmp && (adc_data <= lo_th)) begin
                cmp_nxt = 1'b0;
            end
            if (cmp_nxt) high_nxt = high_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (meas_enable) state_nxt = MEASURE;
            MEASURE: begin
                if (!meas_enable)              state_nxt = IDLE;
                else if (gate_cnt == GATE_LAST) state_nxt = DIVIDE;
            end
            DIVIDE:  if (div_cnt == DIV_LAST) state_nxt = UPDATE;
            UPDATE:  state_nxt = meas_enable ? MEASURE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Restoring division step; a zero divisor yields garbage that UPDATE masks.
    assign rem_sh = {div_rem, div_num[39]};
    assign rem_ge = (rem_sh >= {1'b0, div_den});

    assign pp_diff = win_max - win_min;
    assign pp_cur  = (total_cnt == 32'd0) ? 16'd0 : 16'(pp_diff);
`ifdef AMP_AVG_EN
    assign amp_nxt = 16'(({1'b0, pp_cur} + {1'b0, pp_prev}) >> 1);
`else
    assign amp_nxt = pp_cur;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt  <= '0;
            total_cnt <= '0;
            high_cnt  <= '0;
            edge_cnt  <= '0;
            win_max   <= '0;
            win_min   <= '1;
            mid       <= ADC_W'(DEFAULT_MID);
            cmp       <= 1'b0;
            div_cnt   <= '0;
            div_num   <= '0;
            div_rem   <= '0;
            div_den   <= '0;
            div_quo   <= '0;
        end else begin
            if (start_window) begin
                gate_cnt  <= '0;
                total_cnt <= '0;
                high_cnt  <= '0;
                edge_cnt  <= '0;
                win_max   <= '0;
                win_min   <= '1;
            end else if (state == MEASURE) begin
                gate_cnt  <= gate_cnt + 32'd1;
                total_cnt <= total_nxt;
                high_cnt  <= high_nxt;
                edge_cnt  <= edge_nxt;
                cmp       <= cmp_nxt;
                if (sample_take) begin
                    if (adc_data > win_max) win_max <= adc_data;
                    if (adc_data < win_min) win_min <= adc_data;
                end
            end

            // The last MEASURE sample is folded in through the *_nxt values.
            if (state == MEASURE && state_nxt == DIVIDE) begin
                div_cnt <= '0;
                div_num <= 40'(high_nxt) * 40'd1000;
                div_den <= total_nxt;
                div_rem <= '0;
                div_quo <= '0;
            end else if (state == DIVIDE) begin
                div_cnt <= div_cnt + 6'd1;
                div_num <= {div_num[38:0], 1'b0};
                div_rem <= rem_ge ? 32'(rem_sh - {1'b0, div_den}) : rem_sh[31:0];
                div_quo <= {div_quo[14:0], rem_ge};
            end

            if (state == UPDATE && total_cnt != 32'd0)
                mid <= ADC_W'(({1'b0, win_max} + {1'b0, win_min}) >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq        <= '0;
            amplitude   <= '0;
            duty        <= '0;
            param_valid <= 1'b0;
        end else begin
            param_valid <= (state == UPDATE);
            if (state == UPDATE) begin
                freq      <= edge_cnt;
                amplitude <= amp_nxt;
                duty      <= (total_cnt == 32'd0) ? 16'd0 : div_quo;
            end
        end
    end

`ifdef AMP_AVG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              pp_prev <= '0;
        else if (state == UPDATE) pp_prev <= pp_cur;
    end
`endif

endmodule

// File: tb/tb_signal_param_meter.sv
// Directed bench for signal_param_meter with a short gate window.
module tb_signal_param_meter;

    localparam int G = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        meas_enable = 1'b0;
    logic        adc_valid = 1'b0;
    logic [11:0] adc_data = '0;
    logic [15:0] freq, amplitude, duty;
    logic        param_valid, busy;

    int checks = 0;
    int passed = 0;
    int pp_prev_m = 0;

    signal_param_meter #(
        .GATE_CYCLES(G), .ADC_W(12), .HYST(16), .DEFAULT_MID(2048)
    ) dut (
        .clk(clk), .rst_n(rst_n), .meas_enable(meas_enable),
        .adc_data(adc_data), .adc_valid(adc_valid),
        .freq(freq), .amplitude(amplitude), .duty(duty),
        .param_valid(param_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Modes: 0 const 2048, 1 alt 2050/2040, 2 alt 2062/2028,
    // 3 square 3000/1000, 4 square 2500/1500, 5 no valid samples.
    function automatic logic [11:0] sample_val(input int mode, input int k);
        case (mode)
            0: return 12'd2048;
            1: return (k % 2 == 0) ? 12'd2050 : 12'd2040;
            2: return (k % 2 == 0) ? 12'd2062 : 12'd2028;
            3: return ((k % 100) < 25) ? 12'd3000 : 12'd1000;
            4: return ((k % 100) < 25) ? 12'd2500 : 12'd1500;
            default: return 12'd0;
        endcase
    endfunction

    function automatic int exp_amp(input int pp);
        int r;
`ifdef AMP_AVG_EN
        r = (pp + pp_prev_m) >> 1;
`else
        r = pp;
`endif
        pp_prev_m = pp;
        return r;
    endfunction

    // Called #1 after the edge that enters MEASURE; returns cycles from the
    // first DIVIDE edge to the param_valid strobe.
    task automatic drive_window(input int mode, input bit last, output int lat);
        adc_valid = (mode != 5);
        adc_data  = sample_val(mode, 0);
        for (int k = 1; k < G; k++) begin
            @(posedge clk); #1;
            adc_data = sample_val(mode, k);
        end
        @(posedge clk); #1;
        adc_valid = 1'b1;
        adc_data  = 12'hfff;
        if (last) meas_enable = 1'b0;
        lat = 0;
        while (!param_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic start_window(input int mode, input bit last, output int lat);
        meas_enable = 1'b1;
        @(posedge clk); #1;
        drive_window(mode, last, lat);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (freq !== 16'd0) $display("FAIL reset_freq got=%0d exp=0", freq); else passed++;
        checks++; if (amplitude !== 16'd0) $display("FAIL reset_amp got=%0d exp=0", amplitude); else passed++;
        checks++; if (duty !== 16'd0) $display("FAIL reset_duty got=%0d exp=0", duty); else passed++;
        checks++; if (param_valid !== 1'b0) $display("FAIL reset_pv got=%0b exp=0", param_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else passed++;
    endtask

    task automatic test_window(input string name, input int mode,
                               input int ef, input int epp, input int ed);
        int lat, ea;
        start_window(mode, 1'b1, lat);
        ea = exp_amp(epp);
        checks++; if (lat !== 41) $display("FAIL %s_latency got=%0d exp=41", name, lat); else passed++;
        checks++; if (freq !== 16'(ef)) $display("FAIL %s_freq got=%0d exp=%0d", name, freq, ef); else passed++;
        checks++; if (amplitude !== 16'(ea)) $display("FAIL %s_amp got=%0d exp=%0d", name, amplitude, ea); else passed++;
        checks++; if (duty !== 16'(ed)) $display("FAIL %s_duty got=%0d exp=%0d", name, duty, ed); else passed++;
    endtask

    task automatic test_back_to_back();
        int lat, ea;
        int modes[3] = '{3, 3, 4};
        int pps[3]   = '{2000, 2000, 1000};
        meas_enable = 1'b1;
        @(posedge clk); #1;
        for (int w = 0; w < 3; w++) begin
            drive_window(modes[w], (w == 2), lat);
            ea = exp_amp(pps[w]);
            checks++; if (lat !== 41) $display("FAIL b2b%0d_latency got=%0d exp=41", w, lat); else passed++;
            checks++; if (freq !== 16'd10) $display("FAIL b2b%0d_freq got=%0d exp=10", w, freq); else passed++;
            checks++; if (amplitude !== 16'(ea)) $display("FAIL b2b%0d_amp got=%0d exp=%0d", w, amplitude, ea); else passed++;
            checks++; if (duty !== 16'd250) $display("FAIL b2b%0d_duty got=%0d exp=250", w, duty); else passed++;
        end
        @(posedge clk); #1;
        checks++; if (param_valid !== 1'b0) $display("FAIL strobe_width got=%0b exp=0", param_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL idle_after_update got=%0b exp=0", busy); else passed++;
    endtask

    task automatic test_abort();
        int pulses = 0;
        logic [15:0] hf, ha, hd;
        hf = freq; ha = amplitude; hd = duty;
        meas_enable = 1'b1;
        adc_valid   = 1'b1;
        @(posedge clk); #1;
        adc_data = sample_val(3, 0);
        for (int k = 1; k < 500; k++) begin
            @(posedge clk); #1;
            if (param_valid) pulses++;
            adc_data = sample_val(3, k);
        end
        @(posedge clk); #1;
        meas_enable = 1'b0;
        adc_valid   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%0b exp=0", busy); else passed++;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (param_valid) pulses++;
        end
        checks++; if (pulses !== 0) $display("FAIL abort_no_pv got=%0d pulses exp=0", pulses); else passed++;
        checks++; if (freq !== hf) $display("FAIL abort_hold_freq got=%0d exp=%0d", freq, hf); else passed++;
        checks++; if (amplitude !== ha) $display("FAIL abort_hold_amp got=%0d exp=%0d", amplitude, ha); else passed++;
        checks++; if (duty !== hd) $display("FAIL abort_hold_duty got=%0d exp=%0d", duty, hd); else passed++;
        test_window("restart", 3, 10, 2000, 250);
    endtask

    initial begin
        test_reset();
        test_window("constant", 0, 0, 0, 0);
        test_window("alternating", 1, 0, 10, 0);
        test_window("no_valid", 5, 0, 0, 0);
        // Sensitive to mid being exactly 2045 (left by the alternating window).
        test_window("mid_hold", 2, 500, 34, 500);
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
